// File: rtl/dvi_timing_ctrl_if.sv
// -----------------------------------------------------------------------------
// dvi_timing_ctrl_if
// Configuration channel of the DVI timing controller: one complete timing set
// (horizontal/vertical field widths plus sync polarities) offered to the
// controller, and the controller's accept/reject feedback.
//
// Handshake: a set transfers on any pix_clk edge where cfg_valid && cfg_ready.
// The master holds cfg_valid and all cfg_* fields stable until that edge.
// cfg_ready depends only on controller state, never on cfg_valid. A transferred
// set that fails validation is still consumed; the controller then raises
// cfg_err for exactly one cycle and keeps its current timing.
//
// Signals:
//   cfg_valid            master -> slave  set offered
//   cfg_ready            slave  -> master controller can take a set
//   cfg_h_act/fp/sync/bp master -> slave  horizontal field widths (CW bits)
//   cfg_v_act/fp/sync/bp master -> slave  vertical field widths (CW bits)
//   cfg_hpol, cfg_vpol   master -> slave  sync polarity, 1 = active-high
//   cfg_err              slave  -> master one-cycle pulse: set rejected
// -----------------------------------------------------------------------------
interface dvi_timing_ctrl_if #(
    parameter int CW = 13
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_act;
    logic [CW-1:0] cfg_h_fp;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_h_bp;
    logic [CW-1:0] cfg_v_act;
    logic [CW-1:0] cfg_v_fp;
    logic [CW-1:0] cfg_v_sync;
    logic [CW-1:0] cfg_v_bp;
    logic          cfg_hpol;
    logic          cfg_vpol;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// dvi_timing_ctrl
// Programmable raster timing generator for the TMDS pixel path. Produces the
// pixel coordinate plus DE/HSYNC/VSYNC from an active timing set. New sets
// arrive over the cfg interface, wait in a shadow register, and are applied
// only at a frame boundary (or at once when idle) so a frame is never torn.
//
// Ports:
//   pix_clk      pixel clock, only clock
//   rst          synchronous active-high reset
//   enable       run request; a running frame always completes before idling
//   cfg          dvi_timing_ctrl_if.slave, timing-set handshake
//   x, y         current pixel coordinate (registered)
//   de           active video
//   hsync, vsync sync outputs with polarity applied
//   line_start   pulse at x==0 while running
//   frame_start  pulse at x==0, y==0 while running
//   running      controller in RUN state
//   dbg_state    raw FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module dvi_timing_ctrl #(
    parameter int CW         = 13,
    parameter int DEF_H_ACT  = 1360,
    parameter int DEF_H_FP   = 64,
    parameter int DEF_H_SYNC = 112,
    parameter int DEF_H_BP   = 256,
    parameter int DEF_V_ACT  = 768,
    parameter int DEF_V_FP   = 4,
    parameter int DEF_V_SYNC = 6,
    parameter int DEF_V_BP   = 17,
    parameter bit DEF_HPOL   = 1'b1,
    parameter bit DEF_VPOL   = 1'b1
) (
    input  logic                   pix_clk,
    input  logic                   rst,
    input  logic                   enable,
    dvi_timing_ctrl_if.slave       cfg,
    output logic [CW-1:0]          x,
    output logic [CW-1:0]          y,
    output logic                   de,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   running,
    output logic                   dbg_state
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic          hpol;
        logic          vpol;
    } tset_t;

    localparam tset_t DEF_SET = '{
        h_act: CW'(DEF_H_ACT), h_fp: CW'(DEF_H_FP),
        h_sync: CW'(DEF_H_SYNC), h_bp: CW'(DEF_H_BP),
        v_act: CW'(DEF_V_ACT), v_fp: CW'(DEF_V_FP),
        v_sync: CW'(DEF_V_SYNC), v_bp: CW'(DEF_V_BP),
        hpol: DEF_HPOL, vpol: DEF_VPOL
    };

    localparam logic [CW+1:0] TOT_ONE = (CW+2)'(1);
    localparam logic [CW+1:0] TOT_MAX = {2'b00, {CW{1'b1}}};

    // Totals are two bits wider than the fields so four maximal fields cannot
    // wrap and masquerade as a small legal total.
    function automatic logic [CW+1:0] tot4(input logic [CW-1:0] a, b, c, d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    state_e        state_q, state_d;
    tset_t         act_q, act_d, shd_q, cfg_in;
    logic          pending_q, err_q;
    logic [CW-1:0] x_d, y_d;
    logic [CW+1:0] h_tot, v_tot, in_h_tot, in_v_tot;
    logic [CW+1:0] hs_beg, hs_end, vs_beg, vs_end, xe, ye;
    logic          last_x, last_y, apply, accept, in_ok;
    logic          run_d, de_d, hsync_d, vsync_d, ls_d, fs_d;

    // Incoming set and its validity check.
    assign cfg_in = '{
        h_act: cfg.cfg_h_act, h_fp: cfg.cfg_h_fp,
        h_sync: cfg.cfg_h_sync, h_bp: cfg.cfg_h_bp,
        v_act: cfg.cfg_v_act, v_fp: cfg.cfg_v_fp,
        v_sync: cfg.cfg_v_sync, v_bp: cfg.cfg_v_bp,
        hpol: cfg.cfg_hpol, vpol: cfg.cfg_vpol
    };
    assign in_h_tot = tot4(cfg_in.h_act, cfg_in.h_fp, cfg_in.h_sync, cfg_in.h_bp);
    assign in_v_tot = tot4(cfg_in.v_act, cfg_in.v_fp, cfg_in.v_sync, cfg_in.v_bp);
    assign in_ok    = (|cfg_in.h_act) && (|cfg_in.h_fp) && (|cfg_in.h_sync) &&
                      (|cfg_in.h_bp) && (|cfg_in.v_act) && (|cfg_in.v_fp) &&
                      (|cfg_in.v_sync) && (|cfg_in.v_bp) &&
                      (in_h_tot <= TOT_MAX) && (in_v_tot <= TOT_MAX);

    // Only one set can wait at a time; ready is purely the absence of one.
    assign accept        = cfg.cfg_valid && !pending_q;
    assign cfg.cfg_ready = !pending_q;
    assign cfg.cfg_err   = err_q;

    // Raster wrap points come from the set currently on screen.
    assign h_tot  = tot4(act_q.h_act, act_q.h_fp, act_q.h_sync, act_q.h_bp);
    assign v_tot  = tot4(act_q.v_act, act_q.v_fp, act_q.v_sync, act_q.v_bp);
    assign last_x = ({2'b00, x} == (h_tot - TOT_ONE));
    assign last_y = ({2'b00, y} == (v_tot - TOT_ONE));

    // Next-state / raster advance.
    always_comb begin
        state_d = state_q;
        x_d     = x;
        y_d     = y;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                x_d   = '0;
                y_d   = '0;
                apply = pending_q;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (last_x) begin
                    x_d = '0;
                    if (last_y) begin
                        // Frame boundary: the only place RUN may swap sets or stop.
                        y_d   = '0;
                        apply = pending_q;
                        if (!enable) state_d = IDLE;
                    end else begin
                        y_d = y + CW'(1);
                    end
                end else begin
                    x_d = x + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next coordinate and the next active set so
    // that every registered output lines up with the registered x/y.
    always_comb begin
        act_d   = apply ? shd_q : act_q;
        run_d   = (state_d == RUN);
        xe      = {2'b00, x_d};
        ye      = {2'b00, y_d};
        hs_beg  = {2'b00, act_d.h_act} + {2'b00, act_d.h_fp};
        hs_end  = hs_beg + {2'b00, act_d.h_sync};
        vs_beg  = {2'b00, act_d.v_act} + {2'b00, act_d.v_fp};
        vs_end  = vs_beg + {2'b00, act_d.v_sync};
        de_d    = run_d && (x_d < act_d.h_act) && (y_d < act_d.v_act);
        hsync_d = (run_d && (xe >= hs_beg) && (xe < hs_end)) ^ ~act_d.hpol;
        vsync_d = (run_d && (ye >= vs_beg) && (ye < vs_end)) ^ ~act_d.vpol;
        ls_d    = run_d && (x_d == '0);
        fs_d    = run_d && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            act_q       <= DEF_SET;
            shd_q       <= DEF_SET;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~DEF_HPOL;
            vsync       <= ~DEF_VPOL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            x           <= x_d;
            y           <= y_d;
            de          <= de_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
            // Rejected sets are consumed without touching shadow or active.
            err_q       <= accept && !in_ok;
            // accept needs !pending and apply needs pending, so they never coincide.
            if (apply) begin
                pending_q <= 1'b0;
            end else if (accept && in_ok) begin
                shd_q     <= cfg_in;
                pending_q <= 1'b1;
            end
        end
    end

    assign running   = (state_q == RUN);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_dvi_timing_ctrl.sv
module tb_dvi_timing_ctrl;
  localparam int CW = 13;
  localparam int W  = 2 * CW + 6;

  logic          pix_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          enable  = 1'b0;
  logic [CW-1:0] x, y;
  logic          de, hsync, vsync, line_start, frame_start, running, dbg_state;

  dvi_timing_ctrl_if #(.CW(CW)) cfg_if ();

  dvi_timing_ctrl #(.CW(CW)) dut (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .enable      (enable),
    .cfg         (cfg_if.slave),
    .x           (x),
    .y           (y),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 pix_clk = ~pix_clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference timing set the expected stream is generated from.
  int m_ha, m_hf, m_hs, m_hb, m_va, m_vf, m_vs, m_vb;
  bit m_hp, m_vp;

  function automatic void set_model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                    input bit hp, vp);
    m_ha = ha; m_hf = hf; m_hs = hs; m_hb = hb;
    m_va = va; m_vf = vf; m_vs = vs; m_vb = vb;
    m_hp = hp; m_vp = vp;
  endfunction

  // Word layout: {x, y, de, hsync, vsync, line_start, frame_start, running}
  function automatic logic [W-1:0] pix_word(input int px, input int py);
    logic [CW-1:0] xv, yv;
    logic d, ha, va;
    xv = px[CW-1:0];
    yv = py[CW-1:0];
    d  = (px < m_ha) && (py < m_va);
    ha = (px >= m_ha + m_hf) && (px < m_ha + m_hf + m_hs);
    va = (py >= m_va + m_vf) && (py < m_va + m_vf + m_vs);
    return {xv, yv, d, (ha ? m_hp : ~m_hp), (va ? m_vp : ~m_vp),
            (px == 0), (px == 0 && py == 0), 1'b1};
  endfunction

  function automatic logic [W-1:0] idle_word();
    return {{CW{1'b0}}, {CW{1'b0}}, 1'b0, ~m_hp, ~m_vp, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic string fmt(input logic [W-1:0] w);
    return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b run=%b",
                     w[W-1 -: CW], w[W-CW-1 -: CW], w[5], w[4], w[3], w[2], w[1], w[0]);
  endfunction

  // Push n consecutive raster positions starting at (0,0) of the model set.
  task automatic push_raster(input int n);
    int px = 0;
    int py = 0;
    int ht = m_ha + m_hf + m_hs + m_hb;
    int vt = m_va + m_vf + m_vs + m_vb;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pix_word(px, py));
      px++;
      if (px == ht) begin
        px = 0;
        py++;
        if (py == vt) py = 0;
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(idle_word());
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample(output logic [W-1:0] w);
    @(posedge pix_clk);
    #1;
    w = {x, y, de, hsync, vsync, line_start, frame_start, running};
  endtask

  task automatic drive_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    cfg_if.cfg_h_act  = CW'(ha);
    cfg_if.cfg_h_fp   = CW'(hf);
    cfg_if.cfg_h_sync = CW'(hs);
    cfg_if.cfg_h_bp   = CW'(hb);
    cfg_if.cfg_v_act  = CW'(va);
    cfg_if.cfg_v_fp   = CW'(vf);
    cfg_if.cfg_v_sync = CW'(vs);
    cfg_if.cfg_v_bp   = CW'(vb);
    cfg_if.cfg_hpol   = hp;
    cfg_if.cfg_vpol   = vp;
    cfg_if.cfg_valid  = 1'b1;
  endtask

  task automatic pulse_reset();
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge pix_clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] got, exp;
    enable = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge pix_clk);
    #1;
    set_model(1360, 64, 112, 256, 768, 4, 6, 17, 1'b1, 1'b1);
    got = {x, y, de, hsync, vsync, line_start, frame_start, running};
    exp = idle_word();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL reset_outputs: got %s, expected %s", fmt(got), fmt(exp));
    end else n_pass++;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_if.cfg_ready);
    end else n_pass++;
    n_checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cfg_err: got %b, expected 0", cfg_if.cfg_err);
    end else n_pass++;
    rst = 1'b0;
  endtask

  // First two lines of the default mode plus the start of the third.
  task automatic test_default_lines();
    logic [W-1:0] got, exp;
    push_raster(2 * 1792 + 4);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL default_stream[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end else n_pass++;
    end
    pulse_reset();
  endtask

  // Load the small mode while idle, run two frames, drop enable mid-frame 2.
  task automatic test_small_set(input bit pol);
    logic [W-1:0] got, exp;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL small_ready_before pol=%b: got %b, expected 1", pol, cfg_if.cfg_ready);
    end else n_pass++;
    drive_cfg(4, 1, 2, 1, 2, 1, 1, 1, pol, pol);
    @(posedge pix_clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL small_ready_pending pol=%b: got %b, expected 0", pol, cfg_if.cfg_ready);
    end else n_pass++;
    set_model(4, 1, 2, 1, 2, 1, 1, 1, pol, pol);
    sample(got);
    exp = idle_word();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL small_idle_applied pol=%b: got %s, expected %s", pol, fmt(got), fmt(exp));
    end else n_pass++;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL small_ready_after pol=%b: got %b, expected 1", pol, cfg_if.cfg_ready);
    end else n_pass++;
    push_raster(80);
    push_idle(2);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL small_stream pol=%b [%0d]: got %s, expected %s", pol, i, fmt(got), fmt(exp));
      end else n_pass++;
      if (i == 50) enable = 1'b0;
    end
  endtask

  // Offer h_act=6 mid-frame; a decoy offered on the apply cycle must be ignored.
  task automatic test_mode_change();
    logic [W-1:0] got, exp;
    push_raster(40);
    set_model(6, 1, 2, 1, 2, 1, 1, 1, m_hp, m_vp);
    push_raster(50);
    push_idle(2);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL mode_stream[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end else n_pass++;
      if (i == 10) drive_cfg(6, 1, 2, 1, 2, 1, 1, 1, m_hp, m_vp);
      if (i == 11 || i == 39) begin
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL mode_ready_pending[%0d]: got %b, expected 0", i, cfg_if.cfg_ready);
        end else n_pass++;
      end
      if (i == 39) drive_cfg(2, 1, 1, 1, 2, 1, 1, 1, ~m_hp, ~m_vp);
      if (i == 40 || i == 41) begin
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL mode_ready_applied[%0d]: got %b, expected 1", i, cfg_if.cfg_ready);
        end else n_pass++;
      end
      if (i == 45) enable = 1'b0;
    end
  endtask

  // Zero field and oversized total are both rejected; timing must not change.
  task automatic test_invalid();
    logic [W-1:0] got, exp;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_cfg(3, 1, 0, 1, 2, 1, 1, 1, ~m_hp, ~m_vp);
      else        drive_cfg(8191, 1, 1, 1, 2, 1, 1, 1, ~m_hp, ~m_vp);
      @(posedge pix_clk);
      #1;
      cfg_if.cfg_valid = 1'b0;
      n_checks++;
      if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL invalid_pulse[%0d]: got err=%b ready=%b, expected err=1 ready=1",
                           k, cfg_if.cfg_err, cfg_if.cfg_ready);
      end else n_pass++;
      @(posedge pix_clk);
      #1;
      n_checks++;
      if (cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL invalid_after[%0d]: got err=%b ready=%b, expected err=0 ready=1",
                           k, cfg_if.cfg_err, cfg_if.cfg_ready);
      end else n_pass++;
    end
    push_raster(50);
    push_idle(2);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL invalid_stream[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end else n_pass++;
      if (i == 0) enable = 1'b0;
    end
  endtask

  // Reset mid-line with a set pending: defaults return, pending is lost.
  task automatic test_reset_mid_line();
    logic [W-1:0] got, exp;
    push_raster(14);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rstmid_stream[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end else n_pass++;
      if (i == 5) drive_cfg(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1);
      if (i == 6) begin
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_ready_pending: got %b, expected 0", cfg_if.cfg_ready);
        end else n_pass++;
      end
    end
    pulse_reset();
    set_model(1360, 64, 112, 256, 768, 4, 6, 17, 1'b1, 1'b1);
    got = {x, y, de, hsync, vsync, line_start, frame_start, running};
    exp = idle_word();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL rstmid_state: got %s, expected %s", fmt(got), fmt(exp));
    end else n_pass++;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_cfg: got ready=%b err=%b, expected ready=1 err=0",
                         cfg_if.cfg_ready, cfg_if.cfg_err);
    end else n_pass++;
    push_raster(1800);
    enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      sample(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rstmid_default[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end else n_pass++;
    end
    pulse_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_h_act  = '0;
    cfg_if.cfg_h_fp   = '0;
    cfg_if.cfg_h_sync = '0;
    cfg_if.cfg_h_bp   = '0;
    cfg_if.cfg_v_act  = '0;
    cfg_if.cfg_v_fp   = '0;
    cfg_if.cfg_v_sync = '0;
    cfg_if.cfg_v_bp   = '0;
    cfg_if.cfg_hpol   = 1'b0;
    cfg_if.cfg_vpol   = 1'b0;
    test_reset();
    test_default_lines();
    test_small_set(1'b1);
    test_small_set(1'b0);
    test_mode_change();
    test_invalid();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded 2000000 ns, checks so far %0d", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
